// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
//
// Contents:
//   uart_state_e - receiver FSM states
//   DATA_BITS    - data bits per frame
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // StParity is only reached when the parity option is compiled in.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial input.
// All stages reset to 1 so an idle (high) line is seen during and after reset.
//
// Parameters:
//   STAGES  - number of flops in the chain (>= 2)
// Ports:
//   clk     - clock
//   reset_n - synchronous reset, active-low
//   din     - asynchronous input
//   dout    - synchronised output (last stage)
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver. Synchronises the serial input, validates the start bit at
// mid-bit, then samples each data (and stop) bit at its centre and delivers one byte per
// frame. A low stop bit raises frame_err instead of delivering the byte.
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames with an even-parity check;
// otherwise frames are 8N1 and parity_err is tied low.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit (even, >= 4)
//   SYNC_STAGES  - synchroniser flops (>= 2)
// Ports:
//   clk        - clock
//   reset_n    - synchronous reset, active-low
//   uart_data  - raw serial line, idle high
//   rx_data    - last correctly framed byte
//   rx_dv      - one-cycle pulse, rx_data just updated
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse with rx_dv on parity mismatch
//   busy       - high whenever the receiver is not idle (registered, lags state by a cycle)
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_dv,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntHalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] CntBitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IdxLast     = 3'(DATA_BITS - 1);

  logic                 rx_sync;
  uart_state_e          state;
  logic [CntW-1:0]      cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (uart_data),
    .dout    (rx_sync)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= StIdle;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // Pulses default low; each is asserted for a single cycle below.
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      busy <= (state != StIdle);

      case (state)
        StIdle: begin
          if (!rx_sync) begin
            state <= StStart;
            cnt   <= '0;
          end
        end

        StStart: begin
          if (cnt == CntHalfLast) begin
            cnt <= '0;
            // A line that is already high again at mid-start was only a glitch.
            if (!rx_sync) begin
              state <= StData;
              idx   <= '0;
            end else begin
              state <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StData: begin
          if (cnt == CntBitLast) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            cnt   <= '0;
            idx   <= idx + 3'd1;
            if (idx == IdxLast) begin
`ifdef UART_RX_PARITY_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt == CntBitLast) begin
            par_bit <= rx_sync;
            cnt     <= '0;
            state   <= StStop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        StStop: begin
          if (cnt == CntBitLast) begin
            cnt <= '0;
            if (rx_sync) begin
              rx_data <= shreg;
              rx_dv   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to zero.
              parity_err <= ^{shreg, par_bit};
`endif
              state <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state     <= StWaitIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Hold off until the line goes high so a break is not taken as a new start bit.
        StWaitIdle: begin
          if (rx_sync) begin
            state <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

- Receives 8N1 asynchronous serial data on the board's UART input pin and delivers one byte per frame to the LED panel controller, which consumes it directly downstream.
- Synchronises the input and validates the start bit at mid-bit.
- Samples each data and stop bit at its centre using a parameterised clocks-per-bit counter.
- Flags framing errors instead of delivering corrupt bytes.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: `clk` cycles per serial bit; must be an even value ≥ 4.
- SYNC_STAGES, default 2: flip-flops in the input synchroniser chain; must be ≥ 2.

Ports:
- clk  input  1  block clock, the divided panel clock domain.
- reset_n  input  1  synchronous reset, active-low.
- uart_data  input  1  raw serial line, asynchronous; idle high.
- rx_data  output  8  last correctly framed byte, LSB received first.
- rx_dv  output  1  one-cycle pulse; `rx_data` has just been updated.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).
- busy  output  1  high in every state except IDLE.

## Operation
- `uart_data` passes through SYNC_STAGES flops, all reset to 1. The last stage is `rx_sync`.
- Let H = CLKS_PER_BIT/2 and C = CLKS_PER_BIT. Counter `cnt` has width $clog2(C). Bit index `idx` has width 3.
- State machine:
  - IDLE: when `rx_sync`==0, go to START with `cnt`=0.
  - START: when `cnt`==H-1, go to DATA with `cnt`=0 and `idx`=0 if `rx_sync`==0. If `rx_sync`==1 at that point, treat it as a glitch and return to IDLE with no pulse. Otherwise `cnt`++.
  - DATA: when `cnt`==C-1, shift `rx_sync` into the MSB of the shift register (right shift), set `cnt`=0 and `idx`++. After `idx`==7 is sampled, go to PARITY if compiled in, otherwise STOP. Otherwise `cnt`++.
  - PARITY (compiled in only): when `cnt`==C-1, capture the parity bit, set `cnt`=0, go to STOP.
  - STOP: when `cnt`==C-1:
    - If `rx_sync`==1: set `rx_data` = shift register, pulse `rx_dv` (and `parity_err` if the parity check failed), go to IDLE.
    - If `rx_sync`==0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: go to IDLE on the first cycle `rx_sync`==1. This covers break conditions.
- On a parity failure, `rx_dv` and `parity_err` pulse together and `rx_data` is still updated.
- `rx_dv` and `frame_err` are mutually exclusive.

## Timing
- Reset values: `rx_data`=8'h00, `rx_dv`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state IDLE, synchroniser flops all 1.
- Reset takes priority over every transition. Reset mid-frame discards the partial byte and emits no pulse.
- Edge numbering: edge 0 is the first `clk` edge at which `uart_data` is sampled low.
- Without parity, `rx_dv` is registered at edge SYNC_STAGES + H + 9C. With the defaults that is edge 154. With parity it is C cycles later.
- All pulses are exactly one cycle wide. `rx_data` holds its value until the next valid frame.
- Back-to-back frames: a start edge seen in the cycle immediately after the return to IDLE is accepted. No dead cycles are needed beyond the stop bit.
- `busy` is registered from the state and rises one cycle after IDLE→START.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is 8E1.
  - PARITY state is present.
  - `parity_err` pulses with `rx_dv` when the XOR of the 8 data bits and the parity bit is 1.
- UART_RX_PARITY_EN undefined:
  - Frame is 8N1.
  - PARITY state is absent.
  - `parity_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - localparam DATA_BITS=8.
- Sub-module `uart_rx_sync`: parameterised synchroniser chain (SYNC_STAGES flops, reset to 1).
- The state machine, counters and shift register stay in `uart_rx_oversample`.

## Test plan
- Idle line held high for 500 cycles after reset → no `rx_dv`, `frame_err` or `busy`; `rx_data`=00.
- Frame 0xA5 at C=16 → `rx_dv` one cycle at edge 154, `rx_data`=A5, `frame_err`=0.
- Low glitch of 4 cycles → START aborts at mid-bit, returns to IDLE, no pulses; a following 0x3C frame is received correctly.
- Frame 0x5A with stop bit forced low, line then low for 40 cycles → `frame_err` pulse, `rx_data` keeps its previous value, `busy` stays high until the line returns high; next frame 0x01 gives `rx_dv`.
- `reset_n` low mid-DATA of 0xFF, then frame 0x81 → no pulse for the aborted frame; 0x81 is delivered. Back-to-back 0x00, 0xFF with no idle gap → two `rx_dv` pulses, exactly 10C apart.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → `rx_dv`, `parity_err`=0; the same byte with parity bit 0 → `rx_dv` and `parity_err` pulse together.
